// File: rtl/aes_spi_pkg.sv
// Shared definitions for the AES SPI master/slave pair.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
package aes_spi_pkg;

    // Frame phases in link order
    typedef enum logic [2:0] {
        IDLE,
        SEND_DATA,
        SEND_KEY,
        WAIT,
        RECV,
        FINISH
    } state_t;

    localparam int BLOCK_W = 128;

    // AES round count for a key of nk 32-bit words
    function automatic int nr_of(input int nk);
        return nk + 6;
    endfunction

    // SCLK periods per frame: data out, key out, slave compute gap, result in
    function automatic int frame_len(input int nk, input int wait_sclk);
        return 2 * BLOCK_W + nk * 32 + wait_sclk;
    endfunction

endpackage

// File: rtl/aes_spi_master_spi_clk_div.sv
// SCLK generator: divides clk by CLK_DIV per half-period; strobes mark the clk
//   cycle in which sclk will toggle (rise_tick: 0->1, fall_tick: 1->0).
// Latency: first rise_tick CLK_DIV cycles after clr drops. Backpressure: none.
// Ports: clk, clr (sync clear, holds sclk low), rise_tick, fall_tick, sclk.
module spi_clk_div #(
    parameter int CLK_DIV = 50
) (
    input  logic clk,
    input  logic clr,
    output logic rise_tick,
    output logic fall_tick,
    output logic sclk
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DW-1:0] div_cnt;
    logic          tick;

    assign tick      = (div_cnt == DW'(CLK_DIV - 1));
    assign rise_tick = tick & ~sclk;
    assign fall_tick = tick & sclk;

    always_ff @(posedge clk) begin
        if (clr) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
        end else if (tick) begin
            div_cnt <= '0;
            sclk    <= ~sclk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/aes_spi_master.sv
// SPI mode-0 master: ships one block + NK-word key to the AES slave, waits
//   WAIT_SCLK periods, then reads the 128-bit result back (all fields LSB first).
// Latency: done 2 + 2*CLK_DIV*frame_len(NK,WAIT_SCLK) cycles after start.
// Backpressure: start is only accepted in IDLE and not in the done cycle;
//   starts while busy are dropped, never queued.
// Ports: clk, reset (sync, active high); host side start/mode_in/data_in/key_in
//   in, busy/done/result out; link side sclk/cs_n/mosi/mode out, miso in.
module aes_spi_master
    import aes_spi_pkg::*;
#(
    parameter int NK        = 4,
    parameter int CLK_DIV   = 50,
    parameter int WAIT_SCLK = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 mode_in,
    input  logic [BLOCK_W-1:0]   data_in,
    input  logic [NK*32-1:0]     key_in,
    output logic                 busy,
    output logic                 done,
    output logic [BLOCK_W-1:0]   result,
    output logic                 sclk,
    output logic                 cs_n,
    output logic                 mosi,
    input  logic                 miso,
    output logic                 mode
);

    localparam int KW    = NK * 32;
    localparam int FRAME = frame_len(NK, WAIT_SCLK);
    localparam int CW    = $clog2(FRAME);
    localparam int DIW   = $clog2(BLOCK_W);
    localparam int KIW   = $clog2(KW);

    localparam logic [CW-1:0] LAST_DATA = CW'(BLOCK_W - 1);
    localparam logic [CW-1:0] LAST_KEY  = CW'(KW - 1);
    localparam logic [CW-1:0] LAST_WAIT = CW'(WAIT_SCLK - 1);

    generate
        if (!(NK == 4 || NK == 6 || NK == 8) || CLK_DIV < 2) begin : g_bad_param
            $error("aes_spi_master: NK must be 4, 6 or 8 and CLK_DIV at least 2");
        end
    endgenerate

    state_t             state, state_nxt;
    logic [CW-1:0]      bit_cnt, cnt_nxt, cnt_inc;
    logic [BLOCK_W-1:0] data_sh, data_sh_nxt;
    logic [KW-1:0]      key_sh, key_sh_nxt;
    logic [BLOCK_W-1:0] rx_sh, rx_sh_nxt;
    logic [BLOCK_W-1:0] result_nxt;
    logic               busy_nxt, done_nxt, cs_n_nxt, mosi_nxt, mode_nxt;
    logic               div_clr, rise_tick, fall_tick;

    // Divider only runs while the link is mid-frame, so every frame starts
    // with a full half-period of sclk low after cs_n falls.
    assign div_clr = reset | (state == IDLE) | (state == FINISH);

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .clk       (clk),
        .clr       (div_clr),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick),
        .sclk      (sclk)
    );

    // bit_cnt restarts at 0 in every phase so it indexes each shadow directly
    assign cnt_inc = bit_cnt + 1'b1;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = bit_cnt;
        data_sh_nxt = data_sh;
        key_sh_nxt  = key_sh;
        rx_sh_nxt   = rx_sh;
        result_nxt  = result;
        busy_nxt    = busy;
        done_nxt    = 1'b0;
        cs_n_nxt    = cs_n;
        mosi_nxt    = mosi;
        mode_nxt    = mode;

        case (state)
            IDLE: begin
                // done still high means the previous frame just closed
                if (start && !done) begin
                    data_sh_nxt = data_in;
                    key_sh_nxt  = key_in;
                    mode_nxt    = mode_in;
                    busy_nxt    = 1'b1;
                    cs_n_nxt    = 1'b0;
                    mosi_nxt    = data_in[0];
                    cnt_nxt     = '0;
                    state_nxt   = SEND_DATA;
                end
            end
            SEND_DATA: begin
                if (fall_tick) begin
                    if (bit_cnt == LAST_DATA) begin
                        cnt_nxt   = '0;
                        mosi_nxt  = key_sh[0];
                        state_nxt = SEND_KEY;
                    end else begin
                        cnt_nxt  = cnt_inc;
                        mosi_nxt = data_sh[cnt_inc[DIW-1:0]];
                    end
                end
            end
            SEND_KEY: begin
                if (fall_tick) begin
                    if (bit_cnt == LAST_KEY) begin
                        cnt_nxt   = '0;
                        mosi_nxt  = 1'b0;
                        state_nxt = (WAIT_SCLK == 0) ? RECV : WAIT;
                    end else begin
                        cnt_nxt  = cnt_inc;
                        mosi_nxt = key_sh[cnt_inc[KIW-1:0]];
                    end
                end
            end
            WAIT: begin
                if (fall_tick) begin
                    if (bit_cnt == LAST_WAIT) begin
                        cnt_nxt   = '0;
                        state_nxt = RECV;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
            end
            RECV: begin
                if (rise_tick) begin
                    rx_sh_nxt = {miso, rx_sh[BLOCK_W-1:1]};
                end
                if (fall_tick) begin
                    if (bit_cnt == LAST_DATA) begin
                        cnt_nxt   = '0;
                        state_nxt = FINISH;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
            end
            FINISH: begin
                cs_n_nxt   = 1'b1;
                mosi_nxt   = 1'b0;
                busy_nxt   = 1'b0;
                done_nxt   = 1'b1;
                result_nxt = rx_sh;
                state_nxt  = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            data_sh <= '0;
            key_sh  <= '0;
            rx_sh   <= '0;
            result  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            cs_n    <= 1'b1;
            mosi    <= 1'b0;
            mode    <= 1'b0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= cnt_nxt;
            data_sh <= data_sh_nxt;
            key_sh  <= key_sh_nxt;
            rx_sh   <= rx_sh_nxt;
            result  <= result_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
            cs_n    <= cs_n_nxt;
            mosi    <= mosi_nxt;
            mode    <= mode_nxt;
        end
    end

endmodule

// File: tb/tb_aes_spi_master.sv
// Bench for aes_spi_master: two instances (NK=4/CLK_DIV=3 and NK=8/CLK_DIV=2)
//   talk to a behavioural slave that decodes the frame by counting SCLK edges.
// The slave answers known AES vectors from a table and any other frame with
//   a simple keyed function; the host-side expectation comes from that rule.
module tb_aes_spi_master;

    localparam int NK0  = 4;
    localparam int NK1  = 8;
    localparam int DIV0 = 3;
    localparam int DIV1 = 2;
    localparam int WS   = 16;

    localparam logic [127:0] K128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P1   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C1   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] P2   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C2   = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [1:0] start_v, mode_in_v, busy_v, done_v, sclk_v, cs_n_v, mosi_v, mode_v;
    logic [1:0] miso_v = 2'b00;
    logic [127:0] data_in_a [2];
    logic [255:0] key_in_a [2];
    logic [127:0] result_a [2];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    aes_spi_master #(.NK(NK0), .CLK_DIV(DIV0), .WAIT_SCLK(WS)) dut0 (
        .clk(clk), .reset(reset), .start(start_v[0]), .mode_in(mode_in_v[0]),
        .data_in(data_in_a[0]), .key_in(key_in_a[0][NK0*32-1:0]),
        .busy(busy_v[0]), .done(done_v[0]), .result(result_a[0]),
        .sclk(sclk_v[0]), .cs_n(cs_n_v[0]), .mosi(mosi_v[0]),
        .miso(miso_v[0]), .mode(mode_v[0])
    );

    aes_spi_master #(.NK(NK1), .CLK_DIV(DIV1), .WAIT_SCLK(WS)) dut1 (
        .clk(clk), .reset(reset), .start(start_v[1]), .mode_in(mode_in_v[1]),
        .data_in(data_in_a[1]), .key_in(key_in_a[1][NK1*32-1:0]),
        .busy(busy_v[1]), .done(done_v[1]), .result(result_a[1]),
        .sclk(sclk_v[1]), .cs_n(cs_n_v[1]), .mosi(mosi_v[1]),
        .miso(miso_v[1]), .mode(mode_v[1])
    );

    function automatic int nk_of(input int g);
        return (g == 0) ? NK0 : NK1;
    endfunction

    function automatic int div_of(input int g);
        return (g == 0) ? DIV0 : DIV1;
    endfunction

    function automatic int frame_of(input int g);
        return 256 + nk_of(g) * 32 + WS;
    endfunction

    function automatic logic [255:0] kmask(input int g, input logic [255:0] k);
        return (g == 0) ? {128'h0, k[127:0]} : k;
    endfunction

    // What the slave returns for a received (mode, data, key)
    function automatic logic [127:0] slave_fn(input int g, input logic m,
                                              input logic [127:0] d, input logic [255:0] k);
        if (g == 0 && k[127:0] == K128 && !m && d == P1) return C1;
        if (g == 0 && k[127:0] == K128 &&  m && d == C1) return P1;
        if (g == 1 && k == K256 && !m && d == P2) return C2;
        return d ^ k[255:128] ^ {k[63:0], k[127:64]} ^ {128{m}};
    endfunction

    // ---------------- behavioural slave + protocol monitor ----------------
    int           rises [2]       = '{0, 0};
    int           frame_rises [2] = '{0, 0};
    int           viol [2]        = '{0, 0};
    int           mode_err [2]    = '{0, 0};
    int           done_cnt [2]    = '{0, 0};
    logic [127:0] rx_data [2];
    logic [255:0] rx_key [2];
    logic [127:0] resp [2];
    logic         first_mosi [2];
    logic         mode_exp [2]    = '{1'b0, 1'b0};
    logic         ps [2]          = '{1'b0, 1'b0};
    logic         pm [2]          = '{1'b0, 1'b0};
    logic         pc [2]          = '{1'b1, 1'b1};

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            int kb;
            int base;
            kb   = nk_of(g) * 32;
            base = 128 + kb + WS;
            if (done_v[g]) done_cnt[g]++;
            // mosi may move only with a falling sclk or a cs_n edge
            if (mosi_v[g] !== pm[g] && !(ps[g] && !sclk_v[g]) && cs_n_v[g] === pc[g])
                viol[g]++;
            if (pc[g] && !cs_n_v[g]) begin
                rises[g]      = 0;
                first_mosi[g] = mosi_v[g];
                rx_data[g]    = '0;
                rx_key[g]     = '0;
            end
            if (!pc[g] && cs_n_v[g]) frame_rises[g] = rises[g];
            if (!cs_n_v[g] && !ps[g] && sclk_v[g]) begin
                rises[g]++;
                if (rises[g] <= 128) rx_data[g][rises[g]-1] = mosi_v[g];
                else if (rises[g] <= 128 + kb) rx_key[g][rises[g]-129] = mosi_v[g];
                if (rises[g] == 128 + kb)
                    resp[g] = slave_fn(g, mode_v[g], rx_data[g], rx_key[g]);
                if (mode_v[g] !== mode_exp[g]) mode_err[g]++;
            end
            // result bit j is presented before rise base+j+1; noise elsewhere
            if (ps[g] && !sclk_v[g]) begin
                if (!cs_n_v[g] && rises[g] >= base && rises[g] < base + 128)
                    miso_v[g] = resp[g][rises[g]-base];
                else
                    miso_v[g] = 1'($urandom);
            end
            ps[g] = sclk_v[g];
            pm[g] = mosi_v[g];
            pc[g] = cs_n_v[g];
        end
    end

    // ---------------------------- checking --------------------------------
    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called on a negedge; returns on the negedge after the done cycle.
    task automatic run_frame(input int g, input logic m, input logic [127:0] d,
                             input logic [255:0] k, input logic [127:0] exp_res);
        int cyc;
        int first_rise;
        int busy_low;
        int done_before;
        int dv;
        int fr;
        logic [255:0] km;
        dv          = div_of(g);
        fr          = frame_of(g);
        km          = kmask(g, k);
        done_before = done_cnt[g];
        mode_exp[g] = m;

        start_v[g]   = 1'b1;
        mode_in_v[g] = m;
        data_in_a[g] = d;
        key_in_a[g]  = km;
        @(negedge clk);
        cyc = 1;
        // scramble inputs: the frame must run from the captured copies
        start_v[g]   = 1'b0;
        mode_in_v[g] = ~m;
        data_in_a[g] = {4{$urandom}};
        key_in_a[g]  = {8{$urandom}};
        chk("c1_busy", 256'(busy_v[g]), 256'(1));
        chk("c1_cs_n", 256'(cs_n_v[g]), 256'(0));
        chk("c1_sclk", 256'(sclk_v[g]), 256'(0));
        chk("c1_mosi", 256'(mosi_v[g]), 256'(d[0]));
        chk("c1_mode", 256'(mode_v[g]), 256'(m));

        first_rise = 0;
        busy_low   = 0;
        while (!done_v[g] && cyc < 3 * dv * fr) begin
            @(negedge clk);
            cyc++;
            if (sclk_v[g] && first_rise == 0) first_rise = cyc;
            if (!done_v[g] && !busy_v[g]) busy_low++;
            if (cyc == 40) begin
                start_v[g]   = 1'b1;
                data_in_a[g] = ~d;
                mode_in_v[g] = ~m;
            end
            if (cyc == 41) start_v[g] = 1'b0;
        end
        chk("first_rise_cycle", 256'(first_rise), 256'(1 + dv));
        chk("done_cycle", 256'(cyc), 256'(2 + 2 * dv * fr));
        chk("busy_gap", 256'(busy_low), 256'(0));
        chk("result", 256'(result_a[g]), 256'(exp_res));
        chk("done_busy", 256'(busy_v[g]), 256'(0));
        chk("done_cs_n", 256'(cs_n_v[g]), 256'(1));
        chk("done_sclk", 256'(sclk_v[g]), 256'(0));
        chk("done_mosi", 256'(mosi_v[g]), 256'(0));

        start_v[g] = 1'b1;          // asserted in the done cycle: must be dropped
        @(negedge clk);
        start_v[g] = 1'b0;
        chk("done_one_cycle", 256'(done_v[g]), 256'(0));
        chk("start_in_done_ignored", 256'(busy_v[g]), 256'(0));
        chk("slave_rx_data", 256'(rx_data[g]), 256'(d));
        chk("slave_rx_key", rx_key[g], km);
        chk("first_mosi", 256'(first_mosi[g]), 256'(d[0]));
        chk("bit128_key0", 256'(rx_key[g][0]), 256'(km[0]));
        chk("sclk_rises", 256'(frame_rises[g]), 256'(fr));
        chk("mode_stable", 256'(mode_err[g]), 256'(0));
        chk("mosi_while_sclk_high", 256'(viol[g]), 256'(0));
        chk("done_count", 256'(done_cnt[g] - done_before), 256'(1));
        chk("result_held", 256'(result_a[g]), 256'(exp_res));
    endtask

    typedef struct {
        int           g;
        logic         m;
        logic [127:0] d;
        logic [255:0] k;
        logic [127:0] exp;
    } vec_t;

    initial begin
        vec_t vecs [$];
        vec_t v;
        int   cyc;
        int   done_before;

        start_v      = 2'b00;
        mode_in_v    = 2'b00;
        data_in_a[0] = '0;
        data_in_a[1] = '0;
        key_in_a[0]  = '0;
        key_in_a[1]  = '0;

        // reset state
        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk("rst_busy", 256'(busy_v[g]), 256'(0));
            chk("rst_done", 256'(done_v[g]), 256'(0));
            chk("rst_result", 256'(result_a[g]), 256'(0));
            chk("rst_sclk", 256'(sclk_v[g]), 256'(0));
            chk("rst_cs_n", 256'(cs_n_v[g]), 256'(1));
            chk("rst_mosi", 256'(mosi_v[g]), 256'(0));
            chk("rst_mode", 256'(mode_v[g]), 256'(0));
        end
        reset = 1'b0;
        @(negedge clk);

        // known AES vectors, then randomized frames on both instances
        vecs.push_back('{0, 1'b0, P1, {128'h0, K128}, C1});
        vecs.push_back('{0, 1'b1, C1, {128'h0, K128}, P1});
        vecs.push_back('{1, 1'b0, P2, K256, C2});
        for (int i = 0; i < 4; i++) begin
            v.g = i % 2;
            v.m = 1'($urandom);
            v.d = {4{$urandom}};
            v.k = kmask(v.g, {8{$urandom}});
            v.exp = slave_fn(v.g, v.m, v.d, v.k);
            vecs.push_back(v);
        end
        for (int i = 0; i < vecs.size(); i++)
            run_frame(vecs[i].g, vecs[i].m, vecs[i].d, vecs[i].k, vecs[i].exp);

        // reset in the middle of a frame (around SCLK period 200)
        mode_exp[0]  = 1'b1;
        start_v[0]   = 1'b1;
        mode_in_v[0] = 1'b1;
        data_in_a[0] = C1;
        key_in_a[0]  = {128'h0, K128};
        @(negedge clk);
        start_v[0] = 1'b0;
        cyc = 0;
        while (rises[0] < 200 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        chk("reach_period_200", 256'(rises[0] >= 200), 256'(1));
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_cs_n", 256'(cs_n_v[0]), 256'(1));
        chk("midrst_sclk", 256'(sclk_v[0]), 256'(0));
        chk("midrst_busy", 256'(busy_v[0]), 256'(0));
        chk("midrst_result", 256'(result_a[0]), 256'(0));
        chk("midrst_mosi", 256'(mosi_v[0]), 256'(0));
        chk("midrst_mode", 256'(mode_v[0]), 256'(0));
        chk("midrst_done", 256'(done_v[0]), 256'(0));
        reset = 1'b0;
        done_before = done_cnt[0];
        repeat (20) @(negedge clk);
        chk("midrst_no_done", 256'(done_cnt[0] - done_before), 256'(0));
        run_frame(0, 1'b0, P1, {128'h0, K128}, C1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_spi_master.md
# aes_spi_master

Parametrised SPI master that ships one plaintext/ciphertext block plus an AES key of configurable length to the AES SPI slave. It then reads the 128-bit result back over the same link. It replaces the fixed AES-128, test-vector-only master: the host side gets a start/busy/done handshake, a per-transfer encrypt/decrypt mode, and a programmable SCLK divider. It sits between the system/host logic and the AES slave core.

## Interface
- NK, 4: key length in 32-bit words; legal values 4, 6, 8 (AES-128/192/256).
- CLK_DIV, 50: clk cycles per SCLK half-period; must be at least 2.
- WAIT_SCLK, 16: idle SCLK periods, with CS held low, between the last key bit and the first result bit; this is the slave compute time.

- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- mode_in  in  1  0 = encrypt, 1 = decrypt; captured on start.
- data_in  in  128  block to send; captured on start.
- key_in  in  NK*32  key; captured on start.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse when result is valid.
- result  out  128  received block; held until the next accepted start.
- sclk  out  1  SPI clock, idle low.
- cs_n  out  1  chip select, active low.
- mosi  out  1  serial data to the slave.
- miso  in  1  serial data from the slave.
- mode  out  1  mode to the slave; stable while cs_n is low.

## Operation
- Reset values: busy 0, done 0, result 0, sclk 0, cs_n 1, mosi 0, mode 0. The state is IDLE and all counters are 0.
- States:
  - IDLE: on start, capture data_in, key_in and mode_in into shadow registers, then go to SEND_DATA.
  - SEND_DATA: send 128 data bits, then go to SEND_KEY.
  - SEND_KEY: send NK*32 key bits, then go to WAIT.
  - WAIT: run WAIT_SCLK SCLK periods with mosi at 0, then go to RECV.
  - RECV: receive 128 bits, then go to FINISH.
  - FINISH: raise cs_n, pulse done, then return to IDLE.
- Bit order is LSB first for the data, key and result fields. The bit counter indexes the shadow register directly (bit 0 first).
- SPI mode 0:
  - mosi changes only on SCLK falling edges, or at frame start.
  - The slave samples on rising edges.
  - The master samples miso on each rising edge in RECV and shifts it in from the MSB: result_shift <= {miso, result_shift[127:1]}.
- result is updated from result_shift only in FINISH, so a partial shift is never visible on result.
- start while busy is ignored, with no queueing. Input changes after start have no effect on the current frame.
- mode is driven from the shadow register for the whole frame.

## Timing
- Start cycle is cycle 0. In cycle 1: busy=1, cs_n=0, sclk=0, mosi=data_in[0].
- A divider counts 0..CLK_DIV-1; each wrap is a tick. Ticks alternate rise and fall, with the first tick a rise.
  - First SCLK rising edge: cycle 1+CLK_DIV.
  - Each SCLK period: 2*CLK_DIV clk cycles.
- Frame length: F = 256 + NK*32 + WAIT_SCLK SCLK periods. The defaults give F = 400 periods = 40 000 clk cycles.
- After the F-th falling edge:
  - next cycle: cs_n=1, sclk=0, mosi=0, busy=0, done=1, result valid;
  - the cycle after that: done=0.
- Back-to-back: a start asserted in the cycle done=1 is ignored. A start one cycle later is accepted.
- Reset mid-frame: in the next cycle every output returns to its reset value and result is cleared. No done is produced.
- Counter widths: bit counter is $clog2(256+NK*32+WAIT_SCLK) bits; divider is $clog2(CLK_DIV) bits. Neither counter may wrap within a frame.

## Structure
- Package aes_spi_pkg holds:
  - the state enum (IDLE, SEND_DATA, SEND_KEY, WAIT, RECV, FINISH);
  - BLOCK_W = 128;
  - the function nr_of(NK) = NK+6, shared with the slave;
  - the frame-length function.
- Sub-module spi_clk_div: a CLK_DIV counter producing rise_tick and fall_tick strobes plus the sclk level, with clear on reset or idle.
- An elaboration-time check rejects NK outside {4, 6, 8} and CLK_DIV < 2.

## Test plan
- NK=4, encrypt, key 2b7e151628aed2a6abf7158809cf4f3c, data 3243f6a8885a308d313198a2e0370734, behavioural slave model → result 3925841d02dc09fbdc118597196a0b32, exactly 400 SCLK rises, done one pulse.
- NK=4, decrypt, data 3925841d02dc09fbdc118597196a0b32, same key → result 3243f6a8885a308d313198a2e0370734, mode=1 throughout cs_n low.
- NK=8, encrypt, key 000102…1f, data 00112233445566778899aabbccddeeff → result 8ea2b7ca516745bfeafc49904b496089, 528 SCLK rises.
- Protocol monitor, CLK_DIV=3:
  - mosi never changes while sclk=1;
  - first mosi bit equals data_in[0];
  - bit 128 equals key_in[0];
  - start pulsed during busy → no effect, single done.
- Reset asserted at SCLK period 200 → next cycle cs_n=1, sclk=0, busy=0, result=0, no done; a new start then completes correctly.
